// File: rtl/clk_div_monitor_pkg.sv
// rtl/clk_div_monitor_pkg.sv - state enum, default widths and tolerance compare
package clk_div_monitor_pkg;

    typedef enum logic [1:0] {
        SYNC,
        HIGH,
        LOW
    } state_t;

    localparam int DEFAULT_CNT_W = 8;

    // True when |meas - expected| exceeds tol.
    function automatic logic out_of_tol(input int meas, input int expected, input int tol);
        int diff;
        diff = (meas > expected) ? (meas - expected) : (expected - meas);
        return diff > tol;
    endfunction

endpackage

// File: rtl/clk_div_monitor_edge.sv
// rtl/clk_div_monitor_edge.sv - registered edge detector for the sampled divided clock
module clk_div_monitor_edge (
    input  logic clk_in,
    input  logic rst,
    input  logic div_in,
    output logic rise,
    output logic fall
);

    logic div_q;

    // div_in is already clk_in-synchronous, so one delay stage is enough to find edges
    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_in;
        end
    end

    assign rise = div_in & ~div_q;
    assign fall = ~div_in & div_q;

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - phase-length checker for one divided clock output
module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int EXP_HIGH = 4,
    parameter int EXP_LOW  = 4,
    parameter int TOL      = 0,
    parameter int LOCK_N   = 4,
    parameter int TIMEOUT  = 64,
    parameter int ERR_W    = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic             mismatch,
    output logic             locked,
    output logic             stuck,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TMO_PRE = CNT_W'(TIMEOUT - 1);
    localparam int               GOOD_W      = $clog2(LOCK_N + 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX   = GOOD_W'(LOCK_N);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [CNT_W-1:0]  high_len, high_len_d;
    logic [GOOD_W-1:0] good_run, good_next;
    logic              rise, fall;
    logic              publish, timeout, period_bad;

    clk_div_monitor_edge u_edge (
        .clk_in (clk_in),
        .rst    (rst),
        .div_in (div_in),
        .rise   (rise),
        .fall   (fall)
    );

    // At a publish cnt still holds the length of the low phase that just ended
    assign period_bad = out_of_tol(int'(high_len), EXP_HIGH, TOL)
                     || out_of_tol(int'(cnt), EXP_LOW, TOL);
    assign good_next  = (good_run == GOOD_MAX) ? good_run : good_run + 1'b1;

    // Next-state, phase counter and timeout decode; an edge always wins over a timeout
    always_comb begin
        state_d    = state;
        high_len_d = high_len;
        publish    = 1'b0;
        timeout    = 1'b0;
        cnt_d      = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        case (state)
            SYNC: begin
                if (rise) state_d = HIGH;
            end
            HIGH: begin
                if (fall) begin
                    high_len_d = cnt;
                    state_d    = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    publish = 1'b1;
                    state_d = HIGH;
                end
            end
            default: state_d = SYNC;
        endcase
        if (rise || fall) begin
            cnt_d = CNT_ONE;
        end else if ((cnt == CNT_TMO_PRE) && !stuck) begin
            timeout = 1'b1;
            state_d = SYNC;
        end
    end

    // FSM state, phase counter and captured high length
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= SYNC;
            cnt      <= '0;
            high_len <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            high_len <= high_len_d;
        end
    end

    // Publish register: pulse plus measurements that hold until the next period completes
    always_ff @(posedge clk_in) begin
        if (rst) begin
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;
            meas_high  <= '0;
            meas_low   <= '0;
        end else begin
            meas_valid <= publish;
            mismatch   <= publish && period_bad;
            if (publish) begin
                meas_high <= high_len;
                meas_low  <= cnt;
            end
        end
    end

    // Lock tracking: a run of good periods, cleared by any bad period or a stuck clock
    always_ff @(posedge clk_in) begin
        if (rst) begin
            good_run <= '0;
            locked   <= 1'b0;
        end else if (timeout) begin
            good_run <= '0;
            locked   <= 1'b0;
        end else if (publish) begin
            if (period_bad) begin
                good_run <= '0;
                locked   <= 1'b0;
            end else begin
                good_run <= good_next;
                locked   <= (good_next == GOOD_MAX);
            end
        end
    end

    // Stuck flag and saturating error counter; a stuck episode is counted once on entry
    always_ff @(posedge clk_in) begin
        if (rst) begin
            stuck     <= 1'b0;
            err_count <= '0;
        end else begin
            if (rise) begin
                stuck <= 1'b0;
            end else if (timeout) begin
                stuck <= 1'b1;
            end
            if (((publish && period_bad) || timeout) && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed self-checking bench for clk_div_monitor
module tb_clk_div_monitor;

    logic       clk;
    logic       rst;
    logic       div_in;

    logic       mv [4];
    logic [7:0] mh [4];
    logic [7:0] ml [4];
    logic       mm [4];
    logic       lk [4];
    logic       st [4];
    logic [3:0] ec [4];

    int exp_h [4] = '{1, 4, 14, 3};
    int exp_l [4] = '{1, 4, 14, 2};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the checked instance
    int m_armed, m_h, m_l, m_good, m_err;

    clk_div_monitor #(.CNT_W(8), .EXP_HIGH(1), .EXP_LOW(1), .TOL(0), .LOCK_N(4), .TIMEOUT(64), .ERR_W(4)) u_d11 (
        .clk_in(clk), .rst(rst), .div_in(div_in), .meas_valid(mv[0]), .meas_high(mh[0]), .meas_low(ml[0]),
        .mismatch(mm[0]), .locked(lk[0]), .stuck(st[0]), .err_count(ec[0]));

    clk_div_monitor #(.CNT_W(8), .EXP_HIGH(4), .EXP_LOW(4), .TOL(0), .LOCK_N(4), .TIMEOUT(64), .ERR_W(4)) u_d44 (
        .clk_in(clk), .rst(rst), .div_in(div_in), .meas_valid(mv[1]), .meas_high(mh[1]), .meas_low(ml[1]),
        .mismatch(mm[1]), .locked(lk[1]), .stuck(st[1]), .err_count(ec[1]));

    clk_div_monitor #(.CNT_W(8), .EXP_HIGH(14), .EXP_LOW(14), .TOL(0), .LOCK_N(4), .TIMEOUT(64), .ERR_W(4)) u_d1414 (
        .clk_in(clk), .rst(rst), .div_in(div_in), .meas_valid(mv[2]), .meas_high(mh[2]), .meas_low(ml[2]),
        .mismatch(mm[2]), .locked(lk[2]), .stuck(st[2]), .err_count(ec[2]));

    clk_div_monitor #(.CNT_W(8), .EXP_HIGH(3), .EXP_LOW(2), .TOL(0), .LOCK_N(4), .TIMEOUT(64), .ERR_W(4)) u_d32 (
        .clk_in(clk), .rst(rst), .div_in(div_in), .meas_valid(mv[3]), .meas_high(mh[3]), .meas_low(ml[3]),
        .mismatch(mm[3]), .locked(lk[3]), .stuck(st[3]), .err_count(ec[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int id, input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, id, obs, expv);
        end
    endtask

    // Drive one clk_in cycle of div_in and sample just after the edge
    task automatic step(input logic v);
        div_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        m_armed = 0;
        m_good  = 0;
        m_err   = 0;
    endtask

    // One divided-clock period: h high cycles then l low cycles; the opening rise publishes the previous period
    task automatic period(input int id, input int h, input int l);
        bit bad;
        bad = 1'b0;
        step(1'b1);
        if (m_armed != 0) begin
            bad    = (m_h != exp_h[id]) || (m_l != exp_l[id]);
            m_good = bad ? 0 : ((m_good < 4) ? m_good + 1 : 4);
            if (bad && m_err < 15) m_err++;
        end
        chk(id, "meas_valid", mv[id], (m_armed != 0));
        if (m_armed != 0) begin
            chk(id, "meas_high", mh[id], m_h);
            chk(id, "meas_low", ml[id], m_l);
            chk(id, "mismatch", mm[id], bad);
            chk(id, "locked", lk[id], (m_good == 4));
            chk(id, "err_count", ec[id], m_err);
        end
        chk(id, "stuck", st[id], 0);
        for (int i = 1; i < h; i++) begin
            step(1'b1);
            chk(id, "meas_valid_idle", mv[id], 0);
        end
        for (int i = 0; i < l; i++) begin
            step(1'b0);
            chk(id, "meas_valid_idle", mv[id], 0);
        end
        m_armed = 1;
        m_h     = h;
        m_l     = l;
    endtask

    initial begin
        rst    = 1'b1;
        div_in = 1'b0;
        do_reset();
        for (int id = 0; id < 4; id++) begin
            chk(id, "rst_meas_valid", mv[id], 0);
            chk(id, "rst_meas_high", mh[id], 0);
            chk(id, "rst_meas_low", ml[id], 0);
            chk(id, "rst_mismatch", mm[id], 0);
            chk(id, "rst_locked", lk[id], 0);
            chk(id, "rst_stuck", st[id], 0);
            chk(id, "rst_err_count", ec[id], 0);
        end

        // Divide-by-2 against EXP 1/1
        for (int p = 0; p < 6; p++) period(0, 1, 1);
        chk(0, "div2_locked", lk[0], 1);
        chk(0, "div2_err", ec[0], 0);

        // Divide-by-8 against EXP 4/4
        do_reset();
        for (int p = 0; p < 6; p++) period(1, 4, 4);
        chk(1, "div8_locked", lk[1], 1);
        chk(1, "div8_err", ec[1], 0);

        // Hold div_in low after lock: the fall was 4 cycles ago, stuck lands when cnt reaches 64
        for (int i = 0; i < 59; i++) step(1'b0);
        chk(1, "pre_stuck", st[1], 0);
        chk(1, "pre_stuck_locked", lk[1], 1);
        step(1'b0);
        chk(1, "stuck_set", st[1], 1);
        chk(1, "stuck_locked", lk[1], 0);
        chk(1, "stuck_err", ec[1], 1);
        for (int i = 0; i < 36; i++) step(1'b0);
        chk(1, "stuck_held", st[1], 1);
        chk(1, "stuck_err_once", ec[1], 1);
        m_armed = 0;
        m_good  = 0;
        m_err   = 1;
        for (int p = 0; p < 5; p++) period(1, 4, 4);
        chk(1, "relock", lk[1], 1);
        chk(1, "relock_err", ec[1], 1);

        // Divide-by-28 against EXP 14/14
        do_reset();
        for (int p = 0; p < 6; p++) period(2, 14, 14);
        chk(2, "div28_locked", lk[2], 1);
        chk(2, "div28_err", ec[2], 0);

        // Divide-by-8 against EXP 3/2: every period mismatches, err_count saturates
        do_reset();
        for (int p = 0; p < 17; p++) period(3, 4, 4);
        chk(3, "sat_err", ec[3], 15);
        chk(3, "sat_locked", lk[3], 0);

        // Hand-driven 3/2 pattern with one 4/2 period
        do_reset();
        for (int p = 0; p < 6; p++) period(3, 3, 2);
        chk(3, "p32_locked", lk[3], 1);
        period(3, 4, 2);
        for (int p = 0; p < 5; p++) period(3, 3, 2);
        chk(3, "p32_relock", lk[3], 1);
        chk(3, "p32_err", ec[3], 1);

        // Reset in the middle of a high phase
        do_reset();
        for (int p = 0; p < 3; p++) period(1, 4, 4);
        step(1'b1);
        step(1'b1);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        chk(1, "midrst_meas_valid", mv[1], 0);
        chk(1, "midrst_meas_high", mh[1], 0);
        chk(1, "midrst_meas_low", ml[1], 0);
        chk(1, "midrst_mismatch", mm[1], 0);
        chk(1, "midrst_locked", lk[1], 0);
        chk(1, "midrst_stuck", st[1], 0);
        chk(1, "midrst_err", ec[1], 0);
        m_armed = 0;
        m_good  = 0;
        m_err   = 0;
        period(1, 1, 4);
        period(1, 4, 4);
        period(1, 4, 4);
        chk(1, "midrst_err_after", ec[1], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
